// File: rtl/apb_pkg.sv
// Shared definitions for the two-port APB master and its surroundings.
//   apb_state_t : bus sequencing state, 2-bit encoding
//   APB_ADDR_W  : default address width (register-file class slave)
//   APB_DATA_W  : default data width
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// Bundle of requester-side and APB-side signals of apb_master_arb.
//   master modport : the arbitrating APB master (drives ready, rsp*, APB outputs)
//   slave modport  : the environment (requesters and the APB slave)
// Requester N (N=0,1): reqN_valid/write/addr/wdata in, reqN_ready out,
//   rspN_valid/rdata/err out.  APB: psel, penable, pwrite, paddr, pwdata out;
//   prdata, pready in.
interface apb_master_arb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;

    logic              rsp0_valid, rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              psel, penable, pwrite, pready;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata, prdata;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_err, rsp0_rdata,
        output rsp1_valid, rsp1_err, rsp1_rdata,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_err, rsp0_rdata,
        input  rsp1_valid, rsp1_err, rsp1_rdata,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]  : pending requests
//   last_gnt  : index of the most recent winner
//   advance   : arbitration allowed this cycle; no grant otherwise
//   gnt[1:0]  : one-hot grant, or zero
module apb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       advance,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            // A lone requester always wins; on contention the one that did not win last goes.
            if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Two-port APB master with round-robin arbitration onto one APB slave.
// Each transfer runs IDLE -> SETUP -> ACCESS (held until pready) and the
// result is returned to the requester that issued it as a one-cycle rspN_valid.
// Ports:
//   pclk : clock, rising edge
//   prst : synchronous active-high reset
//   bus  : apb_master_arb_if.master (requester handshakes, responses, APB bus)
// Optional build macro:
//   APB_TIMEOUT_EN : abort an ACCESS after TIMEOUT cycles without pready and
//                    report it with rspN_err; without it ACCESS waits forever.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input logic              pclk,
    input logic              prst,
    apb_master_arb_if.master bus
);

    apb_state_t        state;
    logic              gnt_id;
    logic              last_gnt;
    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [1:0]        rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q [2];

    logic [1:0]        gnt;
    logic              arb_advance;
    logic              win_write;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_cnt;
`endif

    // Grants are only offered while idle; the reset gate keeps ready low
    // through the reset cycles even though state is already IDLE.
    assign arb_advance = (state == APB_IDLE) && !prst;

    apb_rr_arb2 u_arb (
        .req      ({bus.req1_valid, bus.req0_valid}),
        .last_gnt (last_gnt),
        .advance  (arb_advance),
        .gnt      (gnt)
    );

    assign win_write = gnt[1] ? bus.req1_write : bus.req0_write;
    assign win_addr  = gnt[1] ? bus.req1_addr  : bus.req0_addr;
    assign win_wdata = gnt[1] ? bus.req1_wdata : bus.req0_wdata;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state          <= APB_IDLE;
            gnt_id         <= 1'b0;
            last_gnt       <= 1'b1;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            rsp_valid_q    <= 2'b00;
            rsp_err_q      <= 2'b00;
            rsp_rdata_q[0] <= '0;
            rsp_rdata_q[1] <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            rsp_valid_q <= 2'b00;
            case (state)
                APB_IDLE: begin
                    if (gnt != 2'b00) begin
                        gnt_id   <= gnt[1];
                        last_gnt <= gnt[1];
                        pwrite_q <= win_write;
                        paddr_q  <= win_addr;
                        pwdata_q <= win_wdata;
                        psel_q   <= 1'b1;
                        state    <= APB_SETUP;
`ifdef APB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                APB_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    // pready takes priority over a timeout landing in the same cycle.
                    if (bus.pready) begin
                        psel_q              <= 1'b0;
                        penable_q           <= 1'b0;
                        state               <= APB_IDLE;
                        rsp_valid_q[gnt_id] <= 1'b1;
                        rsp_err_q[gnt_id]   <= 1'b0;
                        rsp_rdata_q[gnt_id] <= pwrite_q ? '0 : bus.prdata;
                    end
`ifdef APB_TIMEOUT_EN
                    // Count reaching TIMEOUT on this cycle: abort the transfer.
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        psel_q              <= 1'b0;
                        penable_q           <= 1'b0;
                        state               <= APB_IDLE;
                        rsp_valid_q[gnt_id] <= 1'b1;
                        rsp_err_q[gnt_id]   <= 1'b1;
                        rsp_rdata_q[gnt_id] <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= APB_IDLE;
            endcase
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_err   = rsp_err_q[0];
    assign bus.rsp1_err   = rsp_err_q[1];
    assign bus.rsp0_rdata = rsp_rdata_q[0];
    assign bus.rsp1_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_apb_master_arb.sv
// Bench for apb_master_arb: directed scenarios plus a randomized run checked
// against a transaction-level model (3-cycle service slot, alternating
// contention winner, shadow memory). Build with APB_TIMEOUT_EN to also
// exercise the timeout abort path.
module tb_apb_master_arb;
    import apb_pkg::*;

    localparam int AW  = APB_ADDR_W;
    localparam int DW  = APB_DATA_W;
    localparam int TMO = 4;

    logic pclk;
    logic prst;
    logic slv_clr;
    int   checks   = 0;
    int   failures = 0;

    apb_master_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Behavioural APB slave: register file, read data combinational from paddr.
    logic [DW-1:0] slv_mem [256];
    assign bus.prdata = slv_mem[bus.paddr];
    always @(posedge pclk) begin
        if (slv_clr) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
            slv_mem[bus.paddr] <= bus.pwdata;
        end
    end

    task automatic idle_reqs();
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    task automatic test_reset();
        prst = 1'b1; slv_clr = 1'b1; bus.pready = 1'b1;
        idle_reqs();
        bus.req0_valid = 1'b1; bus.req0_addr = 8'h07;
        repeat (2) begin
            @(negedge pclk); #1;
            checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b exp=0", bus.psel); end
            checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
            checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%b exp=0", bus.req1_ready); end
            checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp0_valid got=%b exp=0", bus.rsp0_valid); end
            checks++; if (bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp1_valid got=%b exp=0", bus.rsp1_valid); end
        end
        checks++; if (bus.penable !== 1'b0) begin failures++; $display("FAIL reset_penable got=%b exp=0", bus.penable); end
        checks++; if (bus.pwrite !== 1'b0) begin failures++; $display("FAIL reset_pwrite got=%b exp=0", bus.pwrite); end
        checks++; if (bus.paddr !== 8'h00) begin failures++; $display("FAIL reset_paddr got=%h exp=00", bus.paddr); end
        checks++; if (bus.pwdata !== 8'h00) begin failures++; $display("FAIL reset_pwdata got=%h exp=00", bus.pwdata); end
        checks++; if (bus.rsp0_rdata !== 8'h00 || bus.rsp1_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=00/00", bus.rsp0_rdata, bus.rsp1_rdata); end
        checks++; if (bus.rsp0_err !== 1'b0 || bus.rsp1_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b/%b exp=0/0", bus.rsp0_err, bus.rsp1_err); end
        bus.req0_valid = 1'b0;
        prst = 1'b0; slv_clr = 1'b0;
    endtask

    task automatic test_write();
        @(negedge pclk);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 8'h03; bus.req0_wdata = 8'hA5;
        bus.pready = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL wr_ready0 got=%b exp=1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL wr_ready1 got=%b exp=0", bus.req1_ready); end
        @(negedge pclk);
        bus.req0_valid = 1'b0;
        checks++; if ({bus.psel, bus.penable} !== 2'b10) begin failures++; $display("FAIL wr_setup psel/pen got=%b exp=10", {bus.psel, bus.penable}); end
        checks++; if ({bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 8'h03, 8'hA5}) begin failures++; $display("FAIL wr_setup fields got=%b/%h/%h exp=1/03/a5", bus.pwrite, bus.paddr, bus.pwdata); end
        @(negedge pclk);
        checks++; if ({bus.psel, bus.penable} !== 2'b11) begin failures++; $display("FAIL wr_access psel/pen got=%b exp=11", {bus.psel, bus.penable}); end
        checks++; if ({bus.pwrite, bus.paddr, bus.pwdata} !== {1'b1, 8'h03, 8'hA5}) begin failures++; $display("FAIL wr_access fields got=%b/%h/%h exp=1/03/a5", bus.pwrite, bus.paddr, bus.pwdata); end
        checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_early got=%b exp=0", bus.rsp0_valid); end
        @(negedge pclk);
        checks++; if (bus.rsp0_valid !== 1'b1) begin failures++; $display("FAIL wr_rsp0_valid got=%b exp=1", bus.rsp0_valid); end
        checks++; if (bus.rsp0_rdata !== 8'h00) begin failures++; $display("FAIL wr_rsp0_rdata got=%h exp=00", bus.rsp0_rdata); end
        checks++; if (bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp1_valid got=%b exp=0", bus.rsp1_valid); end
        checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL wr_psel_drop got=%b exp=0", bus.psel); end
        checks++; if (slv_mem[3] !== 8'hA5) begin failures++; $display("FAIL wr_slave_mem got=%h exp=a5", slv_mem[3]); end
        @(negedge pclk);
        checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_pulse got=%b exp=0", bus.rsp0_valid); end
    endtask

    task automatic test_read();
        @(negedge pclk);
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 8'h03; bus.req1_wdata = 8'h5A;
        #1;
        checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin failures++; $display("FAIL rd_ready got=%b exp=10", {bus.req1_ready, bus.req0_ready}); end
        @(negedge pclk);
        bus.req1_valid = 1'b0;
        @(negedge pclk);
        checks++; if (bus.pwrite !== 1'b0) begin failures++; $display("FAIL rd_pwrite got=%b exp=0", bus.pwrite); end
        @(negedge pclk);
        checks++; if (bus.rsp1_valid !== 1'b1) begin failures++; $display("FAIL rd_rsp1_valid got=%b exp=1", bus.rsp1_valid); end
        checks++; if (bus.rsp1_rdata !== 8'hA5) begin failures++; $display("FAIL rd_rsp1_rdata got=%h exp=a5", bus.rsp1_rdata); end
        checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL rd_rsp0_valid got=%b exp=0", bus.rsp0_valid); end
    endtask

    task automatic test_round_robin();
        int   order[$];
        int   n0 = 0, n1 = 0;
        logic r0 = 1'b0, r1 = 1'b0;
        int   exp_order[4] = '{0, 1, 0, 1};
        bus.req0_write = 1'b0; bus.req0_addr = 8'h10;
        bus.req1_write = 1'b0; bus.req1_addr = 8'h20;
        for (int w = 0; w < 30 && order.size() < 4; w++) begin
            @(negedge pclk);
            // Advance a requester to its next read once its previous one was taken.
            if (r0) begin if (n0 == 2) bus.req0_valid = 1'b0; else bus.req0_addr = bus.req0_addr + 8'h01; end
            if (r1) begin if (n1 == 2) bus.req1_valid = 1'b0; else bus.req1_addr = bus.req1_addr + 8'h01; end
            if (w == 0) begin bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; end
            #1;
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            checks++; if (r0 && r1) begin failures++; $display("FAIL rr_both_ready got=11 exp=onehot"); end
            if (r0) begin order.push_back(0); n0++; end
            if (r1) begin order.push_back(1); n1++; end
        end
        checks++; if (order.size() != 4) begin failures++; $display("FAIL rr_grant_count got=%0d exp=4", order.size()); end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            checks++; if (order[i] != exp_order[i]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]); end
        end
        checks++; if (n0 != 2 || n1 != 2) begin failures++; $display("FAIL rr_per_req got=%0d/%0d exp=2/2", n0, n1); end
        @(negedge pclk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    task automatic test_wait_states();
        int   n_acc = 0;
        logic got = 1'b0;
        @(negedge pclk);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h03;
        bus.pready = 1'b0;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL ws_ready0 got=%b exp=1", bus.req0_ready); end
        @(negedge pclk);
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            if (k == 5) bus.pready = 1'b1;
            checks++; if ({bus.psel, bus.penable, bus.paddr} !== {2'b11, 8'h03}) begin failures++; $display("FAIL ws_hold[%0d] got=%b/%h exp=11/03", k, {bus.psel, bus.penable}, bus.paddr); end
            checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL ws_rsp_early[%0d] got=%b exp=0", k, bus.rsp0_valid); end
        end
        @(negedge pclk);
        checks++; if (bus.rsp0_valid !== 1'b1) begin failures++; $display("FAIL ws_rsp0_valid got=%b exp=1", bus.rsp0_valid); end
        checks++; if (bus.rsp0_rdata !== 8'hA5) begin failures++; $display("FAIL ws_rsp0_rdata got=%h exp=a5", bus.rsp0_rdata); end
        checks++; if (bus.rsp0_err !== 1'b0) begin failures++; $display("FAIL ws_rsp0_err got=%b exp=0", bus.rsp0_err); end
        checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL ws_psel_drop got=%b exp=0", bus.psel); end
`ifdef APB_TIMEOUT_EN
        @(negedge pclk);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h03;
        bus.pready = 1'b0;
        @(negedge pclk);
        bus.req0_valid = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge pclk);
            if (bus.rsp0_valid) got = 1'b1;
            else if (bus.psel && bus.penable) n_acc++;
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL tmo_rsp got=none exp=pulse"); end
        checks++; if (n_acc != TMO) begin failures++; $display("FAIL tmo_access_cycles got=%0d exp=%0d", n_acc, TMO); end
        checks++; if (bus.rsp0_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", bus.rsp0_err); end
        checks++; if (bus.rsp0_rdata !== 8'h00) begin failures++; $display("FAIL tmo_rdata got=%h exp=00", bus.rsp0_rdata); end
        checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL tmo_psel got=%b exp=0", bus.psel); end
        bus.pready = 1'b1;
`else
        checks++; if (got !== 1'b0 || n_acc != 0 || bus.rsp1_err !== 1'b0) begin failures++; $display("FAIL ws_err1 got=%b exp=0", bus.rsp1_err); end
`endif
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_access();
        @(negedge pclk);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h03;
        bus.pready = 1'b0;
        @(negedge pclk);
        bus.req0_valid = 1'b0;
        @(negedge pclk);
        checks++; if ({bus.psel, bus.penable} !== 2'b11) begin failures++; $display("FAIL rst_mid_access got=%b exp=11", {bus.psel, bus.penable}); end
        prst = 1'b1;
        @(negedge pclk);
        checks++; if ({bus.psel, bus.penable} !== 2'b00) begin failures++; $display("FAIL rst_mid_drop got=%b exp=00", {bus.psel, bus.penable}); end
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL rst_mid_rsp got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
        prst = 1'b0; bus.pready = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            checks++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.psel} !== 3'b000) begin failures++; $display("FAIL rst_mid_quiet got=%b exp=000", {bus.rsp0_valid, bus.rsp1_valid, bus.psel}); end
        end
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h03;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL rst_fresh_ready got=%b exp=1", bus.req0_ready); end
        @(negedge pclk);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge pclk);
        checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 8'hA5) begin failures++; $display("FAIL rst_fresh_rsp got=%b/%h exp=1/a5", bus.rsp0_valid, bus.rsp0_rdata); end
    endtask

    task automatic test_random();
        logic [DW-1:0] mdl_mem [256];
        logic          pend [2];
        logic          pw   [2];
        logic [AW-1:0] pa   [2];
        logic [DW-1:0] pd   [2];
        int            free_at = 0;
        int            last    = 1;
        int            acc_w   = -10;
        logic [AW-1:0] acc_addr = '0;
        int            rsp_due = -10;
        int            rsp_who = 0;
        logic [DW-1:0] rsp_dat = '0;
        int            win;
        logic          ev0, ev1, exp_psel, exp_pen, er0, er1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        @(negedge pclk);
        idle_reqs(); bus.pready = 1'b1; prst = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
        for (int i = 0; i < 256; i++) mdl_mem[i] = slv_mem[i];
        for (int w = 0; w < 400; w++) begin
            @(negedge pclk);
            ev0 = (w == rsp_due) && (rsp_who == 0);
            ev1 = (w == rsp_due) && (rsp_who == 1);
            checks++; if (bus.rsp0_valid !== ev0) begin failures++; $display("FAIL rnd_rsp0_valid w=%0d got=%b exp=%b", w, bus.rsp0_valid, ev0); end
            checks++; if (bus.rsp1_valid !== ev1) begin failures++; $display("FAIL rnd_rsp1_valid w=%0d got=%b exp=%b", w, bus.rsp1_valid, ev1); end
            if (ev0) begin checks++; if (bus.rsp0_rdata !== rsp_dat) begin failures++; $display("FAIL rnd_rsp0_rdata w=%0d got=%h exp=%h", w, bus.rsp0_rdata, rsp_dat); end end
            if (ev1) begin checks++; if (bus.rsp1_rdata !== rsp_dat) begin failures++; $display("FAIL rnd_rsp1_rdata w=%0d got=%h exp=%h", w, bus.rsp1_rdata, rsp_dat); end end
            exp_psel = (w == acc_w + 1) || (w == acc_w + 2);
            exp_pen  = (w == acc_w + 2);
            checks++; if ({bus.psel, bus.penable} !== {exp_psel, exp_pen}) begin failures++; $display("FAIL rnd_apb_phase w=%0d got=%b exp=%b", w, {bus.psel, bus.penable}, {exp_psel, exp_pen}); end
            if (exp_psel) begin checks++; if (bus.paddr !== acc_addr) begin failures++; $display("FAIL rnd_paddr w=%0d got=%h exp=%h", w, bus.paddr, acc_addr); end end
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 2) != 0) begin
                    pend[n] = 1'b1;
                    pw[n]   = 1'($urandom_range(0, 1));
                    pa[n]   = AW'($urandom_range(0, 7));
                    pd[n]   = DW'($urandom);
                end
            end
            bus.req0_valid = pend[0]; bus.req0_write = pw[0]; bus.req0_addr = pa[0]; bus.req0_wdata = pd[0];
            bus.req1_valid = pend[1]; bus.req1_write = pw[1]; bus.req1_addr = pa[1]; bus.req1_wdata = pd[1];
            #1;
            er0 = 1'b0; er1 = 1'b0; win = -1;
            if (w >= free_at && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) win = 1 - last;
                else                    win = pend[1] ? 1 : 0;
                if (win == 0) er0 = 1'b1; else er1 = 1'b1;
            end
            checks++; if ({bus.req1_ready, bus.req0_ready} !== {er1, er0}) begin failures++; $display("FAIL rnd_ready w=%0d got=%b exp=%b", w, {bus.req1_ready, bus.req0_ready}, {er1, er0}); end
            if (win >= 0) begin
                last     = win;
                free_at  = w + 3;
                acc_w    = w;
                acc_addr = pa[win];
                rsp_due  = w + 3;
                rsp_who  = win;
                rsp_dat  = pw[win] ? '0 : mdl_mem[pa[win]];
                if (pw[win]) mdl_mem[pa[win]] = pd[win];
                pend[win] = 1'b0;
            end
        end
        @(negedge pclk);
        idle_reqs();
        repeat (3) @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_wait_states();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
